truth_table_bist: RTL
=====================

Name: truth_table_bist

Overview:
- Hardware self-test engine for small combinational blocks such as the 2-input implication gate (o_c = ~i_a | i_b).
- Steps exhaustively through every input vector, drives it onto the DUT inputs and waits a fixed settle time.
- Samples the DUT output and compares it against a parameterised expected truth table.
- Sits beside the DUT as the on-chip counterpart of a directed testbench: it generates stimulus and checks responses. Results are exposed through a start/busy/done handshake.

Parameters:
N_INPUTS, 2, number of DUT inputs; vectors 0 .. 2^N_INPUTS-1
EXPECTED, 4'b1011, width 2^N_INPUTS; bit v = expected DUT output for input vector v (MSB of vector = first DUT input)
SETTLE_CYCLES, 2, cycles a vector is held before the compare cycle; legal range >= 1

Ports:
i_clk  input  1  clock, rising edge
i_rst_n  input  1  asynchronous active-low reset
i_start  input  1  run request, sampled only in IDLE
o_busy  output  1  high while a run is in progress
o_done  output  1  one-cycle pulse when a run completes
o_pass  output  1  1 = last run had zero mismatches; valid when o_done pulses, held until next start
o_err_count  output  N_INPUTS+1  number of mismatching vectors in last run
o_fail_mask  output  2^N_INPUTS  bit v set if vector v mismatched
o_dut_in  output  N_INPUTS  stimulus vector to DUT
i_dut_out  input  1  DUT response, same clock domain, combinational path from o_dut_in

Behaviour:
- Reset: asynchronous, active low. Takes effect immediately, including mid-run.
  - FSM returns to IDLE.
  - o_busy, o_done, o_pass, o_err_count, o_fail_mask, o_dut_in all 0.
  - Internal settle counter and vector index are cleared.
- FSM states: IDLE, SETTLE, CHECK, DONE.
- IDLE:
  - i_start=1 at an edge: go to SETTLE, vector index=0, o_dut_in=0, o_busy=1, settle count=0.
  - On the same edge, o_err_count, o_fail_mask and o_pass clear to 0.
- SETTLE: counter increments each cycle. After SETTLE_CYCLES cycles in SETTLE, go to CHECK.
- CHECK: lasts one cycle. At its ending edge:
  - i_dut_out is compared with EXPECTED[index].
  - On mismatch, set o_fail_mask[index] and increment o_err_count.
  - If index is not the last vector: index+1, o_dut_in updates, return to SETTLE.
  - If index is the last vector: go to DONE.
- Vector hold time: o_dut_in holds each vector for exactly SETTLE_CYCLES+1 cycles. It changes only on the edge leaving CHECK.
- DONE: lasts one cycle.
  - o_done=1 and o_busy=0 in this cycle.
  - o_pass = (o_err_count==0) is registered on entry.
  - Next edge: go to IDLE, o_done=0.
- Latency: i_start edge to the o_done-high cycle is 2^N_INPUTS*(SETTLE_CYCLES+1)+1 cycles (defaults: 13).
- o_dut_in after a run stays at the last vector (all ones) until the next start or reset.
- i_start in SETTLE, CHECK or DONE is ignored, with no queueing. A new run needs i_start high in IDLE.
- Result fields hold their values in IDLE until the next accepted start.
- o_err_count cannot overflow: its width holds 2^N_INPUTS.
- A mismatch is defined as i_dut_out != EXPECTED[index]. No X detection in RTL.

Test Plan:
- Implication DUT, defaults, one start pulse:
  - o_dut_in sequence 00,01,10,11, each held 3 cycles.
  - o_done pulses 13 cycles after the start edge.
  - o_pass=1, o_err_count=0, o_fail_mask=4'b0000.
- i_dut_out tied 1 -> o_pass=0, o_err_count=1, o_fail_mask=4'b0100.
- i_dut_out tied 0 -> o_pass=0, o_err_count=3, o_fail_mask=4'b1011.
- i_start held high for the whole run -> exactly one run, then a new run starts from the IDLE edge after DONE.
  - Results from the first run clear on that restart edge.
- Extra i_start pulse mid-run -> ignored; single o_done.
- i_rst_n low for 1 cycle while vector 01 is applied:
  - All outputs 0 immediately, without waiting for a clock edge.
  - o_busy=0, no o_done.
  - The next start performs a full 4-vector run with correct results.
- SETTLE_CYCLES=1, N_INPUTS=2 -> each vector held 2 cycles; o_done 9 cycles after start.

Source files
------------

// File: rtl/truth_table_bist.sv
// Exhaustive truth-table self-test: walks every input vector through a small
// combinational DUT, waits a settle time, and records per-vector mismatches.
module truth_table_bist #(
  parameter int unsigned N_INPUTS = 2,
  parameter logic [(2**N_INPUTS)-1:0] EXPECTED = 4'b1011,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_start,
  output logic                      o_busy,
  output logic                      o_done,
  output logic                      o_pass,
  output logic [N_INPUTS:0]         o_err_count,
  output logic [(2**N_INPUTS)-1:0]  o_fail_mask,
  output logic [N_INPUTS-1:0]       o_dut_in,
  input  logic                      i_dut_out
);

  localparam int unsigned N_VEC = 2**N_INPUTS;
  localparam int unsigned ERR_W = N_INPUTS + 1;
  localparam int unsigned CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  localparam logic [CNT_W-1:0]    SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]    CNT_ONE     = CNT_W'(1'b1);
  localparam logic [N_INPUTS-1:0] IDX_ONE     = N_INPUTS'(1'b1);
  localparam logic [N_INPUTS-1:0] IDX_LAST    = '1;
  localparam logic [ERR_W-1:0]    ERR_ONE     = ERR_W'(1'b1);
  localparam logic [N_VEC-1:0]    MASK_ONE    = N_VEC'(1'b1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_CHECK  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t               state_r, state_s;
  logic [CNT_W-1:0]     cnt_r, cnt_s;
  logic [N_INPUTS-1:0]  idx_r, idx_s;
  logic                 busy_r, busy_s;
  logic                 done_r, done_s;
  logic                 pass_r, pass_s;
  logic [ERR_W-1:0]     err_r, err_s;
  logic [N_VEC-1:0]     mask_r, mask_s;
  logic                 mismatch_s;

  function automatic logic expected_bit(input logic [N_INPUTS-1:0] vec);
    return EXPECTED[vec];
  endfunction

  // Next-state and next-result logic; results only move on accepted start or CHECK.
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r;
    idx_s      = idx_r;
    busy_s     = busy_r;
    done_s     = 1'b0;
    pass_s     = pass_r;
    err_s      = err_r;
    mask_s     = mask_r;
    mismatch_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (i_start) begin
          state_s = ST_SETTLE;
          cnt_s   = '0;
          idx_s   = '0;
          busy_s  = 1'b1;
          pass_s  = 1'b0;
          err_s   = '0;
          mask_s  = '0;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SETTLE: begin
        if (cnt_r == SETTLE_LAST) begin
          state_s = ST_CHECK;
          cnt_s   = '0;
        end else begin
          cnt_s   = cnt_r + CNT_ONE;
        end
      end
      ST_CHECK: begin
        mismatch_s = (i_dut_out != expected_bit(idx_r));
        if (mismatch_s) begin
          err_s  = err_r + ERR_ONE;
          mask_s = mask_r | (MASK_ONE << idx_r);
        end else begin
          err_s  = err_r;
        end
        // The last vector stays on the DUT pins after the run.
        if (idx_r == IDX_LAST) begin
          state_s = ST_DONE;
          busy_s  = 1'b0;
          done_s  = 1'b1;
          pass_s  = (err_s == '0);
        end else begin
          state_s = ST_SETTLE;
          idx_s   = idx_r + IDX_ONE;
          cnt_s   = '0;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
        busy_s  = 1'b0;
      end
    endcase
  end

  // State and result registers, cleared asynchronously at any point of a run.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r <= ST_IDLE;
      cnt_r   <= '0;
      idx_r   <= '0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      pass_r  <= 1'b0;
      err_r   <= '0;
      mask_r  <= '0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      idx_r   <= idx_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
      pass_r  <= pass_s;
      err_r   <= err_s;
      mask_r  <= mask_s;
    end
  end

  assign o_busy      = busy_r;
  assign o_done      = done_r;
  assign o_pass      = pass_r;
  assign o_err_count = err_r;
  assign o_fail_mask = mask_r;
  assign o_dut_in    = idx_r;

endmodule
